ram_n: RTL and testbench

Parametrised random-access memory that succeeds the fixed 8×16 RAM in the memory hierarchy. It has a configurable word width and depth, keeps the combinational read and clocked write semantics, and adds a hardware zero-clear sweep. The sweep runs automatically after reset and can also be requested on demand, with a `busy` flag exposed while it runs. It is the base for building RAM64/RAM512/RAM4K-style blocks without hand-instantiated trees.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_clear_ctrl.sv | 66 ++++++
 rtl/ram_n.sv | 83 ++++++++
 tb/tb_ram_n.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised RAM (ram_n) and its clear controller.
// Contents: clear-sweep FSM state enum and default geometry constants.
// Optional feature macro used by ram_n: RAM_N_BYPASS_EN (write-through read path).
package ram_pkg;

    typedef enum logic [0:0] {
        RAM_IDLE  = 1'b0,
        RAM_CLEAR = 1'b1
    } ram_state_e;

    localparam int unsigned RAM_WIDTH_DEF  = 16;
    localparam int unsigned RAM_ADDR_W_DEF = 3;

endpackage

// File: rtl/ram_clear_ctrl.sv
// Zero-clear sweep controller for ram_n.
// Walks a pointer over every word, requesting a zero write each cycle, both
// after reset and on a synchronous clear request.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (forces a fresh sweep)
//   clear    in   request to zero the whole array (ignored while sweeping)
//   busy     out  sweep in progress
//   clr_we   out  zero-write strobe for the array write port
//   clr_addr out  word being zeroed this cycle
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // Reset lands in CLEAR so the array (which has no reset of its own) is swept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RAM_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = ptr_q;
        unique case (state_q)
            RAM_IDLE: begin
                if (clear) begin
                    state_d = RAM_CLEAR;
                    ptr_d   = '0;
                end
            end
            RAM_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                // Wrap to 0 coincides with leaving CLEAR; clear requests are ignored here.
                ptr_d  = ptr_q + ADDR_W'(1);
                if (ptr_q == '1) begin
                    state_d = RAM_IDLE;
                end
            end
            default: begin
                state_d = RAM_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ram_n.sv
// Parametrised RAM: combinational read, clocked write, hardware zero-clear sweep.
// Depth is 2**ADDR_W. Writes are dropped while busy or when clear is requested.
// Optional macro RAM_N_BYPASS_EN: while idle with load=1 and clear=0, out
// shows in combinationally (write-through). Undefined by default.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset (starts a clear sweep)
//   in      in   write data
//   load    in   write enable
//   address in   read/write address
//   clear   in   request to zero the whole array
//   out     out  read data (0 while busy)
//   busy    out  clear sweep in progress
module ram_n
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH  = RAM_WIDTH_DEF,
    parameter int unsigned ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;

    ram_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Sweep owns the write port while busy; a same-cycle clear drops the user write.
    always_comb begin
        we    = 1'b0;
        waddr = address;
        wdata = in;
        if (clr_we) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = '0;
        end else if (load && !clear) begin
            we = 1'b1;
        end
    end

    // No reset on the array: it is zeroed by the sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        out = '0;
        if (!busy) begin
            out = mem[address];
`ifdef RAM_N_BYPASS_EN
            if (load && !clear) begin
                out = in;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ram_n.sv
// Self-checking bench for ram_n: a default 16x8 instance and a 32x64 instance.
// Stimulus pushes expectations just after a rising edge; a monitor compares
// them at the following falling edge.
module tb_ram_n;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        load;
    logic [2:0]  address;
    logic        clear;
    logic [15:0] dout;
    logic        busy;

    logic [31:0] din_w;
    logic        load_w;
    logic [5:0]  address_w;
    logic        clear_w;
    logic [31:0] dout_w;
    logic        busy_w;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_val_q [$];
    int          exp_kind_q [$];
    string       exp_tag_q [$];

`ifdef RAM_N_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    ram_n u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (din),
        .load    (load),
        .address (address),
        .clear   (clear),
        .out     (dout),
        .busy    (busy)
    );

    ram_n #(
        .WIDTH  (32),
        .ADDR_W (6)
    ) u_dut_w (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (din_w),
        .load    (load_w),
        .address (address_w),
        .clear   (clear_w),
        .out     (dout_w),
        .busy    (busy_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares every pending expectation against the DUT at the falling edge.
    always @(negedge clk) begin
        while (exp_val_q.size() > 0) begin
            logic [31:0] e;
            logic [31:0] a;
            int          k;
            string       t;
            e = exp_val_q.pop_front();
            k = exp_kind_q.pop_front();
            t = exp_tag_q.pop_front();
            case (k)
                0:       a = {16'h0, dout};
                1:       a = {31'h0, busy};
                2:       a = dout_w;
                default: a = {31'h0, busy_w};
            endcase
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", t, a, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = out, 1 = busy, 2 = wide out, 3 = wide busy
    task automatic expect_v(input int kind, input logic [31:0] v, input string tag);
        exp_val_q.push_back(v);
        exp_kind_q.push_back(kind);
        exp_tag_q.push_back(tag);
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] v, input string tag);
        address = a;
        expect_v(0, {16'h0, v}, tag);
        tick();
    endtask

    task automatic rd_w(input logic [5:0] a, input logic [31:0] v, input string tag);
        address_w = a;
        expect_v(2, v, tag);
        tick();
    endtask

    // Release reset just after an edge and check busy across the following 64 edges.
    task automatic release_and_sweep(input string tag);
        rst_n = 1'b1;
        expect_v(1, 32'd1, {tag, "_busy_e0"});
        expect_v(3, 32'd1, {tag, "_busyw_e0"});
        for (int e = 1; e <= 64; e++) begin
            tick();
            if (e <= 8) expect_v(1, (e < 8) ? 32'd1 : 32'd0, $sformatf("%s_busy_e%0d", tag, e));
            if (e >= 62) expect_v(3, (e < 64) ? 32'd1 : 32'd0, $sformatf("%s_busyw_e%0d", tag, e));
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        load      = 1'b0;
        address   = 3'd4;
        clear     = 1'b0;
        din_w     = '0;
        load_w    = 1'b0;
        address_w = '0;
        clear_w   = 1'b0;

        // Reset: out and busy held
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_v(0, 32'd0, "rst_out");
            expect_v(1, 32'd1, "rst_busy");
        end
        tick();
        release_and_sweep("sweep1");
        for (int a = 0; a < 8; a++) rd(3'(a), 16'd0, $sformatf("sweep1_addr%0d", a));

        // Basic write/read
        load    = 1'b1;
        address = 3'd1;
        din     = 16'd31;
        expect_v(0, BYPASS ? 32'd31 : 32'd0, "wr1_pre_edge");
        tick();
        load = 1'b0;
        rd(3'd1, 16'd31, "wr1_readback");
        rd(3'd0, 16'd0, "wr1_addr0");
        rd(3'd3, 16'd0, "wr1_addr3");

        // Writes during a sweep are dropped
        clear = 1'b1;
        expect_v(1, 32'd0, "clr1_busy_pre");
        tick();
        clear = 1'b0;
        load  = 1'b1;
        din   = 16'd13107;
        address = 3'd3;
        for (int i = 0; i < 8; i++) begin
            expect_v(1, 32'd1, $sformatf("clr1_busy_c%0d", i));
            expect_v(0, 32'd0, $sformatf("clr1_out_c%0d", i));
            tick();
        end
        load = 1'b0;
        expect_v(1, 32'd0, "clr1_busy_done");
        tick();
        rd(3'd3, 16'd0, "clr1_addr3");
        rd(3'd1, 16'd0, "clr1_addr1");

        // clear and load on the same edge: clear wins
        clear   = 1'b1;
        load    = 1'b1;
        address = 3'd7;
        din     = 16'd30583;
        expect_v(0, 32'd0, "clrld_out_pre");
        tick();
        clear = 1'b0;
        load  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_v(1, 32'd1, $sformatf("clrld_busy_c%0d", i));
            tick();
        end
        expect_v(1, 32'd0, "clrld_busy_done");
        tick();
        rd(3'd7, 16'd0, "clrld_addr7");

        // Bypass / legacy write visibility
        load    = 1'b1;
        address = 3'd2;
        din     = 16'd54321;
        expect_v(0, BYPASS ? 32'd54321 : 32'd0, "byp_pre_edge");
        tick();
        load = 1'b0;
        rd(3'd2, 16'd54321, "byp_post_edge");

        // Reset in the middle of a sweep
        load    = 1'b1;
        address = 3'd5;
        din     = 16'd12345;
        tick();
        load = 1'b0;
        rd(3'd5, 16'd12345, "mid_pre");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        expect_v(1, 32'd1, "mid_rst_busy");
        expect_v(0, 32'd0, "mid_rst_out");
        tick();
        release_and_sweep("mid");
        rd(3'd5, 16'd0, "mid_addr5");
        rd(3'd2, 16'd0, "mid_addr2");

        // Wide instance
        load_w    = 1'b1;
        address_w = 6'd63;
        din_w     = 32'hDEAD_BEEF;
        tick();
        address_w = 6'd0;
        din_w     = 32'h1;
        tick();
        load_w = 1'b0;
        rd_w(6'd63, 32'hDEAD_BEEF, "wide_addr63");
        rd_w(6'd0, 32'h1, "wide_addr0");
        rd_w(6'd31, 32'h0, "wide_addr31");

        tick();
        if (exp_val_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", exp_val_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
